divider_sc_mem_ctrl: RTL and testbench
======================================

DIVIDER_SC_MEM_CTRL -- requirements
Module: divider_sc_mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 8, scratch-memory line address width.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to process a job; sampled only in IDLE.
REQ-005 Port: num_groups  input  8  number of 8-value groups in the job; sampled with start.
REQ-006 Port: src_base / dst_base  input  ADDR_W each  first CDF line address / first result line address; sampled with start.
REQ-007 Port: mem_rd_en  output  1  scratch-memory read strobe; read data is valid one cycle later.
REQ-008 Port: mem_addr  output  ADDR_W  scratch-memory line address for reads and writes.
REQ-009 Port: mem_rd_data  input  128  scratch-memory read data.
REQ-010 Port: mem_wt_en / mem_wt_data  output  1 / 128  scratch-memory write strobe and data.
REQ-011 Port: sc_mem_rd_data1 / sc_mem_rd_data2  output  128 each  CDF lines to the divider datapath (values 1-4 / values 5-8, value 1 in bits [31:0]).
REQ-012 Port: sc_mem_rd_data_rdy  output  1  one-cycle pulse: both CDF lines valid.
REQ-013 Port: all_div_done  input  1  AND of the eight divider done flags.
REQ-014 Port: sc_mem_wt_data  input  128  result line from the divider datapath.
REQ-015 Port: busy / done  output  1 / 1  job in progress / one-cycle job-complete pulse.

Function
REQ-016 States: IDLE, RD1, RD2, RD3, PRESENT, HOLD, WAIT_DIV, COLLECT, WT1, WT2, NEXT.
REQ-017 IDLE: start=1 and num_groups!=0 -> RD1, latch bases and count, clear group index g, busy=1. start=1 and num_groups=0 -> done pulses next cycle, stay IDLE.
REQ-018 RD1: mem_rd_en=1, mem_addr=src_base+2g -> RD2.
REQ-019 RD2: mem_rd_en=1, mem_addr=src_base+2g+1, capture mem_rd_data into sc_mem_rd_data1 -> RD3.
REQ-020 RD3: capture mem_rd_data into sc_mem_rd_data2 -> PRESENT.
REQ-021 PRESENT: sc_mem_rd_data_rdy=1 for exactly this cycle -> HOLD; HOLD -> WAIT_DIV.
REQ-022 sc_mem_rd_data1/2 change only in RD2/RD3 and are otherwise held stable, including during PRESENT and HOLD.
REQ-023 WAIT_DIV: all_div_done=1 in cycle N -> COLLECT with 3-bit delay counter cleared; all_div_done levels in other states are ignored.
REQ-024 Result capture: sc_mem_wt_data is sampled in cycle N+2 (line 1) and cycle N+5 (line 2), counted by the delay counter in COLLECT/WT1.
REQ-025 WT1: cycle N+3, mem_wt_en=1, mem_addr=dst_base+2g, mem_wt_data=line 1.
REQ-026 WT2: cycle N+6, mem_wt_en=1, mem_addr=dst_base+2g+1, mem_wt_data=line 2.
REQ-027 NEXT: g increments; g==num_groups -> IDLE with done=1 for one cycle and busy=0; otherwise -> RD1.
REQ-028 Address arithmetic is modulo 2^ADDR_W; base+2g+1 wraps silently.
REQ-029 mem_rd_en and mem_wt_en are never high in the same cycle, and each is high for exactly one cycle per access.
REQ-030 start while busy=1 is ignored, and the latched job parameters are unchanged.
REQ-031 All outputs are registered.

Reset
REQ-032 Reset asserted at any time forces IDLE immediately; busy, done, sc_mem_rd_data_rdy, mem_rd_en and mem_wt_en=0; mem_addr=0; sc_mem_rd_data1/2=0; mem_wt_data=0; g=0.
REQ-033 Reset mid-job abandons the job, performs no further memory writes, and requires a new start.

Verification
REQ-034 Single group: src_base=0x10, dst_base=0x40, mem[0x10]=A and mem[0x11]=B, start, all_div_done 10 cycles after rdy, sc_mem_wt_data=X at N+2 and Y at N+5 -> sc_mem_rd_data1=A and sc_mem_rd_data2=B at rdy, mem[0x40]=X, mem[0x41]=Y, one done pulse.
REQ-035 num_groups=3 -> reads 0x10..0x15 in order, three rdy pulses, writes 0x40..0x45 in order, done after the last write.
REQ-036 Wrap: src_base=0xFF, num_groups=1 -> reads at 0xFF then 0x00.
REQ-037 Simultaneous events: start pulsed while busy, all_div_done held high from reset -> no second job, and no write until a WAIT_DIV sample of all_div_done.
REQ-038 Reset asserted in the cycle after WT1 -> no WT2 write, outputs at reset values, and a new start runs cleanly.
REQ-039 num_groups=0 -> done pulses one cycle after start, with no memory access and busy=0 throughout.

Source files
------------

// File: rtl/divider_sc_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : divider_sc_mem_ctrl_if
// Brief   : Job, scratch-memory and divider-datapath signals of the controller
// Revision: 1.0  initial release
// ============================================================================
interface divider_sc_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        num_groups;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_rd_data;
  logic              mem_wt_en;
  logic [127:0]      mem_wt_data;
  logic [127:0]      sc_mem_rd_data1;
  logic [127:0]      sc_mem_rd_data2;
  logic              sc_mem_rd_data_rdy;
  logic              all_div_done;
  logic [127:0]      sc_mem_wt_data;

  // master: the controller, which owns the scratch-memory bus
  modport master (
    input  start, num_groups, src_base, dst_base, mem_rd_data, all_div_done, sc_mem_wt_data,
    output busy, done, mem_rd_en, mem_addr, mem_wt_en, mem_wt_data,
           sc_mem_rd_data1, sc_mem_rd_data2, sc_mem_rd_data_rdy
  );

  modport slave (
    output start, num_groups, src_base, dst_base, mem_rd_data, all_div_done, sc_mem_wt_data,
    input  busy, done, mem_rd_en, mem_addr, mem_wt_en, mem_wt_data,
           sc_mem_rd_data1, sc_mem_rd_data2, sc_mem_rd_data_rdy
  );
endinterface
`default_nettype wire

// File: rtl/divider_sc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : divider_sc_mem_ctrl
// Brief   : Streams CDF line pairs from scratch memory to the divider datapath
//           and writes the two result lines back, one 8-value group at a time.
// Revision: 1.0  initial release
// ============================================================================
module divider_sc_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  divider_sc_mem_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD1      = 4'd1,
    RD2      = 4'd2,
    RD3      = 4'd3,
    PRESENT  = 4'd4,
    HOLD     = 4'd5,
    WAIT_DIV = 4'd6,
    COLLECT  = 4'd7,
    WT1      = 4'd8,
    WT2      = 4'd9,
    NEXT     = 4'd10
  } state_e;

  state_e            state_q;
  logic [7:0]        g_q;
  logic [7:0]        count_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [2:0]        dly_q;
  logic              busy_q;
  logic              done_q;
  logic              rdy_q;
  logic              rd_en_q;
  logic              wt_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      wt_data_q;
  logic [127:0]      sc1_q;
  logic [127:0]      sc2_q;

  logic [7:0]        g_next_d;
  logic [ADDR_W-1:0] g_off_d;
  logic [ADDR_W-1:0] g_next_off_d;

  // Each group occupies two consecutive lines; offsets wrap with the address width.
  assign g_next_d     = g_q + 8'd1;
  assign g_off_d      = ADDR_W'({g_q, 1'b0});
  assign g_next_off_d = ADDR_W'({g_next_d, 1'b0});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      count_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      dly_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wt_en_q   <= 1'b0;
      addr_q    <= '0;
      wt_data_q <= '0;
      sc1_q     <= '0;
      sc2_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wt_en_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_groups != 8'd0) begin
              state_q <= RD1;
              busy_q  <= 1'b1;
              count_q <= bus.num_groups;
              src_q   <= bus.src_base;
              dst_q   <= bus.dst_base;
              g_q     <= '0;
              rd_en_q <= 1'b1;
              addr_q  <= bus.src_base;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD1: begin
          state_q <= RD2;
          rd_en_q <= 1'b1;
          addr_q  <= src_q + g_off_d + C_ADDR_ONE;
        end
        RD2: begin
          state_q <= RD3;
          sc1_q   <= bus.mem_rd_data;
        end
        RD3: begin
          state_q <= PRESENT;
          sc2_q   <= bus.mem_rd_data;
          rdy_q   <= 1'b1;
        end
        PRESENT: state_q <= HOLD;
        HOLD:    state_q <= WAIT_DIV;
        WAIT_DIV: begin
          if (bus.all_div_done) begin
            state_q <= COLLECT;
            dly_q   <= '0;
          end
        end
        // Result line 1 arrives two cycles after the done sample, line 2 three later.
        COLLECT: begin
          dly_q <= dly_q + 3'd1;
          if (dly_q == 3'd1) begin
            state_q   <= WT1;
            wt_en_q   <= 1'b1;
            addr_q    <= dst_q + g_off_d;
            wt_data_q <= bus.sc_mem_wt_data;
          end
        end
        WT1: begin
          dly_q <= dly_q + 3'd1;
          if (dly_q == 3'd4) begin
            state_q   <= WT2;
            wt_en_q   <= 1'b1;
            addr_q    <= dst_q + g_off_d + C_ADDR_ONE;
            wt_data_q <= bus.sc_mem_wt_data;
          end
        end
        WT2: state_q <= NEXT;
        NEXT: begin
          g_q <= g_next_d;
          if (g_next_d == count_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD1;
            rd_en_q <= 1'b1;
            addr_q  <= src_q + g_next_off_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.mem_rd_en          = rd_en_q;
  assign bus.mem_addr           = addr_q;
  assign bus.mem_wt_en          = wt_en_q;
  assign bus.mem_wt_data        = wt_data_q;
  assign bus.sc_mem_rd_data1    = sc1_q;
  assign bus.sc_mem_rd_data2    = sc2_q;
  assign bus.sc_mem_rd_data_rdy = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_sc_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_sc_mem_ctrl
// Brief   : Directed bench with a scratch-memory model, divider stub and
//           event scoreboard for divider_sc_mem_ctrl.
// Revision: 1.0  initial release
// ============================================================================
module tb_divider_sc_mem_ctrl;

  typedef struct {
    int           cyc;
    logic [7:0]   addr;
    logic [127:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_done = 0;

  logic [127:0] mem [256];
  logic [7:0]   exp_rd[$];
  logic [255:0] exp_rdy[$];
  wr_t          exp_wr[$];

  divider_sc_mem_ctrl_if #(.ADDR_W(8)) bus ();

  divider_sc_mem_ctrl #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  function automatic logic [127:0] pattern(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, 24'h111111, a, 24'h222222, a, 24'h333333, a, 24'h444444};
  endfunction

  // Scratch memory: read data one cycle after the strobe, writes on the edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pattern(i);
    bus.mem_rd_data = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
      if (bus.mem_wt_en) mem[bus.mem_addr] <= bus.mem_wt_data;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",  256'(bus.busy), 256'(0));
    chk("rst_done",  256'(bus.done), 256'(0));
    chk("rst_rdy",   256'(bus.sc_mem_rd_data_rdy), 256'(0));
    chk("rst_rd_en", 256'(bus.mem_rd_en), 256'(0));
    chk("rst_wt_en", 256'(bus.mem_wt_en), 256'(0));
    chk("rst_addr",  256'(bus.mem_addr), 256'(0));
    chk("rst_wdata", 256'(bus.mem_wt_data), 256'(0));
    chk("rst_sc",    {bus.sc_mem_rd_data1, bus.sc_mem_rd_data2}, 256'(0));
  endtask

  // Scoreboard: every access, presentation and completion must match the model.
  initial begin
    logic [255:0] last_sc;
    logic         hold_pending;
    wr_t          w;
    hold_pending = 1'b0;
    last_sc      = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rd_wt_exclusive", 256'(bus.mem_rd_en & bus.mem_wt_en), 256'(0));
        if (bus.mem_rd_en) begin
          chk("read_expected", 256'(exp_rd.size() != 0), 256'(1));
          if (exp_rd.size() != 0) chk("read_addr", 256'(bus.mem_addr), 256'(exp_rd.pop_front()));
        end
        if (bus.mem_wt_en) begin
          chk("write_expected", 256'(exp_wr.size() != 0), 256'(1));
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("write_cycle", 256'(cyc), 256'(w.cyc));
            chk("write_addr",  256'(bus.mem_addr), 256'(w.addr));
            chk("write_data",  256'(bus.mem_wt_data), 256'(w.data));
          end
        end
        if (hold_pending) begin
          chk("sc_hold_stable", {bus.sc_mem_rd_data1, bus.sc_mem_rd_data2}, last_sc);
          hold_pending = 1'b0;
        end
        if (bus.sc_mem_rd_data_rdy) begin
          chk("rdy_expected", 256'(exp_rdy.size() != 0), 256'(1));
          if (exp_rdy.size() != 0) chk("rdy_lines", {bus.sc_mem_rd_data1, bus.sc_mem_rd_data2}, exp_rdy.pop_front());
          last_sc      = {bus.sc_mem_rd_data1, bus.sc_mem_rd_data2};
          hold_pending = 1'b1;
        end
        if (bus.done) begin
          chk("done_expected",     256'(exp_done > 0), 256'(1));
          chk("done_busy_low",     256'(bus.busy), 256'(0));
          chk("done_after_writes", 256'(exp_wr.size()), 256'(0));
          if (exp_done > 0) exp_done--;
        end
      end
    end
  end

  task automatic start_job(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] n);
    logic [7:0] a0;
    logic [7:0] a1;
    for (int g = 0; g < int'(n); g++) begin
      a0 = src + 8'(2 * g);
      a1 = a0 + 8'd1;
      exp_rd.push_back(a0);
      exp_rd.push_back(a1);
      exp_rdy.push_back({mem[a0], mem[a1]});
    end
    exp_done++;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_groups = n; bus.src_base = src; bus.dst_base = dst;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.num_groups = 8'($urandom);
    bus.src_base   = 8'($urandom);
    bus.dst_base   = 8'($urandom);
  endtask

  task automatic wait_rdy(output int rc);
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.sc_mem_rd_data_rdy) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) chk("rdy_timeout", 256'(0), 256'(1));
  endtask

  // Divider stub: done at cycle N, result lines at N+2 and N+5; optional abort reset at N+4.
  task automatic serve_group(input logic [127:0] x, input logic [127:0] y, input logic [7:0] dst,
                             input int g, input bit hold, input bit abort);
    int rc;
    int n;
    wr_t w;
    wait_rdy(rc);
    if (rc < 0) return;
    n = rc + (hold ? 2 : 10);
    w.cyc = n + 3; w.addr = dst + 8'(2 * g); w.data = x;
    exp_wr.push_back(w);
    if (!abort) begin
      w.cyc = n + 6; w.addr = dst + 8'(2 * g + 1); w.data = y;
      exp_wr.push_back(w);
    end
    forever begin
      @(posedge clk); #1;
      bus.all_div_done   = hold ? 1'b1 : (cyc == n);
      bus.sc_mem_wt_data = (cyc == n + 2) ? x : (cyc == n + 5) ? y :
                           {$urandom, $urandom, $urandom, $urandom};
      if (abort && cyc == n + 4) begin
        reset = 1'b1;
        exp_rd.delete();
        exp_rdy.delete();
        exp_done = 0;
        break;
      end
      if (cyc == n + 5) break;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_done > 0; i++) @(negedge clk);
    chk("job_done_seen", 256'(exp_done), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.num_groups = '0; bus.src_base = '0; bus.dst_base = '0;
    bus.all_div_done = 1'b0; bus.sc_mem_wt_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single group
    start_job(8'h10, 8'h40, 8'd1);
    serve_group(128'h11112222333344445555666677778888, 128'h99990000AAAABBBBCCCCDDDDEEEEFFFF, 8'h40, 0, 0, 0);
    wait_done();
    chk("lit_mem40", mem[8'h40], 128'h11112222333344445555666677778888);
    chk("lit_mem41", mem[8'h41], 128'h99990000AAAABBBBCCCCDDDDEEEEFFFF);
    chk("lit_sc1",   bus.sc_mem_rd_data1, 128'h10111111102222221033333310444444);
    chk("lit_sc2",   bus.sc_mem_rd_data2, 128'h11111111112222221133333311444444);

    // Three groups
    start_job(8'h10, 8'h40, 8'd3);
    for (int g = 0; g < 3; g++)
      serve_group(128'h5A00 + 128'(2 * g), 128'h5A00 + 128'(2 * g + 1), 8'h40, g, 0, 0);
    wait_done();
    chk("lit_mem44", mem[8'h44], 128'h5A04);
    chk("lit_mem45", mem[8'h45], 128'h5A05);

    // Source address wrap
    start_job(8'hFF, 8'h60, 8'd1);
    serve_group(128'h6060, 128'h6161, 8'h60, 0, 0, 0);
    wait_done();
    chk("lit_wrap_sc1", bus.sc_mem_rd_data1, 128'hFF111111FF222222FF333333FF444444);
    chk("lit_wrap_sc2", bus.sc_mem_rd_data2, 128'h00111111002222220033333300444444);

    // all_div_done held high, start pulsed while busy
    bus.all_div_done = 1'b1;
    start_job(8'h20, 8'h70, 8'd2);
    serve_group(128'h7070, 128'h7171, 8'h70, 0, 1, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_groups = 8'd5; bus.src_base = 8'h80; bus.dst_base = 8'hC0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    serve_group(128'h7272, 128'h7373, 8'h70, 1, 1, 0);
    wait_done();
    bus.all_div_done = 1'b0;
    repeat (20) @(negedge clk);
    chk("lit_memC0_untouched", mem[8'hC0], 128'hC0111111C0222222C0333333C0444444);

    // Reset after the first result write
    start_job(8'h30, 8'h90, 8'd1);
    serve_group(128'h9090, 128'h9191, 8'h90, 0, 0, 1);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("lit_mem90", mem[8'h90], 128'h9090);
    chk("lit_mem91_untouched", mem[8'h91], 128'h91111111912222229133333391444444);

    // Clean restart after the abort
    start_job(8'h34, 8'hA0, 8'd1);
    serve_group(128'hA0A0, 128'hA1A1, 8'hA0, 0, 0, 0);
    wait_done();
    chk("lit_memA1", mem[8'hA1], 128'hA1A1);

    // Empty job
    start_job(8'h50, 8'h50, 8'd0);
    @(negedge clk);
    chk("zero_done", 256'(bus.done), 256'(1));
    chk("zero_busy", 256'(bus.busy), 256'(0));
    repeat (10) @(negedge clk);
    chk("zero_busy_after", 256'(bus.busy), 256'(0));
    chk("zero_done_once", 256'(exp_done), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
